branch_resolve_unit: RTL
========================

Name: branch_resolve_unit

Overview:
- Writer side of the branch predictor's update interface. Tracks every predicted branch from decode in program order, in a 2-in/2-out queue.
- Compares each branch's prediction with the resolved outcome from execute.
- Drives the predictor's update bus (branch, taken, PC, target per slot).
- Raises a flush with the corrected fetch PC when a branch was mispredicted.
- Sits between the decode/execute pipeline stages and the predictor/fetch PC mux.

Parameters:
- PC_W, 11, width of PCs and targets.
- DEPTH, 8, number of in-flight branch entries. Must be a power of 2 and ≥ 4.
- CNT_W, 16, width of the mispredict counter.

Ports:
- clk  in  1  clock; all logic rises on posedge.
- reset  in  1  synchronous, active-high reset.
- enq_valid1 / enq_valid2  in  1  decode slot 1/2 holds a predicted branch.
- enq_pc1 / enq_pc2  in  PC_W  branch PC.
- enq_pred_taken1 / enq_pred_taken2  in  1  predicted direction.
- enq_pred_target1 / enq_pred_target2  in  PC_W  predicted target.
- enq_ready  out  1  at least 2 free entries.
- res_valid1 / res_valid2  in  1  execute resolves the oldest / second-oldest entry.
- res_taken1 / res_taken2  in  1  actual direction.
- res_target1 / res_target2  in  PC_W  actual taken-target.
- upd_branch1 / upd_branch2  out  1  predictor update strobe.
- upd_taken1 / upd_taken2  out  1  actual direction.
- upd_pc1 / upd_pc2  out  PC_W  PC of the resolved branch.
- upd_target1 / upd_target2  out  PC_W  actual target.
- flush  out  1  one-cycle mispredict pulse.
- redirect_pc  out  PC_W  corrected fetch PC, valid while flush = 1.
- occupancy  out  $clog2(DEPTH)+1  live entry count.
- mispredict_count  out  CNT_W  saturating count of mispredicts.

Behaviour:
- Reset (synchronous, reset = 1 at posedge):
  - Queue emptied, head and tail set to 0.
  - All upd_* outputs, flush, redirect_pc, occupancy and mispredict_count go to 0.
  - enq_ready = 1.
  - Reset overrides all same-cycle enqueues and resolves; in-flight entries are discarded.
- enq_ready is combinational: (DEPTH − occupancy) ≥ 2, computed from the registered occupancy.
- Enqueue:
  - Accepted only when enq_ready = 1; otherwise dropped silently.
  - Slot 1 is written at tail, slot 2 at tail+1.
  - enq_valid2 without enq_valid1 is ignored.
  - Tail advances by the number accepted (0/1/2), modulo DEPTH.
- Resolve:
  - res_valid1 pairs with the head entry; res_valid2 pairs with head+1.
  - res_valid2 without res_valid1 is ignored.
  - A resolve with no matching live entry is ignored.
- Mispredict test for each resolved entry:
  - pred_taken ≠ res_taken, or
  - pred_taken = res_taken = 1 and pred_target ≠ res_target.
- Corrected PC = res_taken ? res_target : pc + 1, modulo 2^PC_W (wraps).
- Cycle N (resolve cycle), no mispredict:
  - Resolved entries are popped.
  - At N+1, upd_branch = 1 with the registered taken/pc/target for each resolved slot; other upd_branch = 0.
- Cycle N, mispredict in slot 1:
  - Slot 2's resolve is wrong-path and is discarded; no update is issued for it.
  - At N+1: flush = 1, redirect_pc = slot 1's corrected PC, upd_branch1 = 1, upd_branch2 = 0.
- Cycle N, slot 1 correct and slot 2 mispredicts:
  - At N+1, both updates are issued, flush = 1, redirect_pc = slot 2's corrected PC.
- On any mispredict:
  - The queue is emptied at N+1 (occupancy 0).
  - Enqueues presented in cycle N are discarded (wrong path).
  - mispredict_count increments by 1, saturating at all-ones.
- Simultaneous enqueue and resolve without mispredict:
  - Both take effect.
  - occupancy_next = occupancy + accepted − popped.
- Update and flush latency is exactly 1 cycle. Outputs are registered, with no combinational input-to-output path except enq_ready.
- Flush is a single-cycle pulse. Back-to-back mispredicts in cycles N and N+1 produce flush in N+1 and N+2.

Decomposition:
- Shared package branch_pkg:
  - PC_W constant.
  - Struct br_entry_t {pc, pred_taken, pred_target}.
  - Function next_seq_pc(pc) returning pc + 1 with wrap.
- One sub-module, branch_queue: a circular buffer of br_entry_t with 2 write ports, 2 read ports (head, head+1), a pop count of 0/1/2, a clear input and an occupancy output.
- Comparison, update registers, flush and counter logic live in the top module.

Test Plan:
- Reset → every output is 0, enq_ready = 1. Enqueue PC 0x010, pred not-taken; next cycle resolve not-taken → upd_branch1 = 1, upd_pc1 = 0x010, upd_taken1 = 0, flush = 0, occupancy returns to 0.
- Enqueue PC 0x020 predicted taken to 0x040; resolve taken with target 0x050 → flush = 1, redirect_pc = 0x050, mispredict_count = 1, occupancy = 0.
- Enqueue PCs 0x030/0x031, both pred not-taken; resolve slot 1 taken to 0x100 and slot 2 not-taken in the same cycle → upd_branch1 = 1, upd_branch2 = 0, redirect_pc = 0x100.
- Enqueue PC 0x7FF pred taken, resolve not-taken → redirect_pc = 0x000 (wrap).
- Fill to occupancy 7 → enq_ready = 0. A pair enqueued then is dropped and occupancy stays 7. One resolve brings it to 6 and enq_ready = 1.
- Assert reset while 3 entries are in flight and a resolve is presented → no upd_branch, no flush, occupancy = 0 in the next cycle. Also force mispredict_count to saturation: it holds at 0xFFFF.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types for the branch resolve path: PC width, queue entry, sequential-PC helper.
// Latency: none; this file holds declarations only.
// Backpressure: none.
package branch_pkg;

    localparam int PC_W = 11;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            pred_taken;
        logic [PC_W-1:0] pred_target;
    } br_entry_t;

    // Fall-through PC of a branch; wraps naturally at 2^PC_W.
    function automatic logic [PC_W-1:0] next_seq_pc(input logic [PC_W-1:0] pc);
        return pc + {{(PC_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/branch_queue.sv
// In-order circular buffer of predicted branches, 2 writes at tail, 2 reads at head/head+1.
// Latency: a write is readable the cycle after it is accepted; reads are combinational from storage.
// Backpressure: none here; the caller only writes when space exists and only pops live entries.
module branch_queue
    import branch_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     wr_en1,
    input  logic                     wr_en2,
    input  br_entry_t                wr_dat1,
    input  br_entry_t                wr_dat2,
    input  logic [1:0]               pop_cnt,
    output br_entry_t                rd_dat1,
    output br_entry_t                rd_dat2,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int AW = $clog2(DEPTH);

    br_entry_t       mem [DEPTH];
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic [AW-1:0]   head_p1;
    logic [AW-1:0]   tail_p1;
    logic [1:0]      wr_cnt;

    // Slot 2 is only written together with slot 1, so the write count is 0/1/2.
    assign wr_cnt  = {1'b0, wr_en1} + {1'b0, wr_en1 & wr_en2};
    assign head_p1 = head + AW'(1);
    assign tail_p1 = tail + AW'(1);
    assign rd_dat1 = mem[head];
    assign rd_dat2 = mem[head_p1];

    // Entry storage; contents past the live window are don't-care, so no reset.
    always_ff @(posedge clk) begin
        if (!reset && !clear) begin
            if (wr_en1) begin
                mem[tail] <= wr_dat1;
            end
            if (wr_en1 && wr_en2) begin
                mem[tail_p1] <= wr_dat2;
            end
        end
    end

    // Pointer and occupancy update; clear drops every in-flight entry.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
        end else begin
            head      <= head + AW'(pop_cnt);
            tail      <= tail + AW'(wr_cnt);
            occupancy <= occupancy + (AW+1)'(wr_cnt) - (AW+1)'(pop_cnt);
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Tracks predicted branches in order, checks them at resolve, drives predictor updates and flush.
// Latency: updates, flush and redirect are registered, 1 cycle after the resolve.
// Backpressure: enq_ready drops when fewer than 2 entries are free; enqueues while low are dropped.
module branch_resolve_unit
    import branch_pkg::*;
#(
    // Must match branch_pkg::PC_W, which sizes the queue entries.
    parameter int PC_W  = branch_pkg::PC_W,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enq_valid1,
    input  logic                   enq_valid2,
    input  logic [PC_W-1:0]        enq_pc1,
    input  logic [PC_W-1:0]        enq_pc2,
    input  logic                   enq_pred_taken1,
    input  logic                   enq_pred_taken2,
    input  logic [PC_W-1:0]        enq_pred_target1,
    input  logic [PC_W-1:0]        enq_pred_target2,
    output logic                   enq_ready,
    input  logic                   res_valid1,
    input  logic                   res_valid2,
    input  logic                   res_taken1,
    input  logic                   res_taken2,
    input  logic [PC_W-1:0]        res_target1,
    input  logic [PC_W-1:0]        res_target2,
    output logic                   upd_branch1,
    output logic                   upd_branch2,
    output logic                   upd_taken1,
    output logic                   upd_taken2,
    output logic [PC_W-1:0]        upd_pc1,
    output logic [PC_W-1:0]        upd_pc2,
    output logic [PC_W-1:0]        upd_target1,
    output logic [PC_W-1:0]        upd_target2,
    output logic                   flush,
    output logic [PC_W-1:0]        redirect_pc,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic [CNT_W-1:0]       mispredict_count
);

    localparam int OW = $clog2(DEPTH) + 1;

    br_entry_t       head_ent1;
    br_entry_t       head_ent2;
    br_entry_t       enq_ent1;
    br_entry_t       enq_ent2;
    logic            acc1, acc2;
    logic            rsv1, rsv2;
    logic            mis1, mis2, any_mis;
    logic [1:0]      pop_cnt;
    logic [PC_W-1:0] corr_pc1, corr_pc2;

    function automatic logic is_mispredict(input br_entry_t e, input logic taken,
                                           input logic [PC_W-1:0] target);
        return (e.pred_taken != taken) || (taken && (e.pred_target != target));
    endfunction

    assign enq_ready = (occupancy <= OW'(DEPTH - 2));

    assign enq_ent1 = '{pc: enq_pc1, pred_taken: enq_pred_taken1, pred_target: enq_pred_target1};
    assign enq_ent2 = '{pc: enq_pc2, pred_taken: enq_pred_taken2, pred_target: enq_pred_target2};

    // Accept, resolve-pairing and mispredict decisions; slot 2 never acts without slot 1.
    always_comb begin
        acc1     = enq_ready && enq_valid1;
        acc2     = acc1 && enq_valid2;
        rsv1     = res_valid1 && (occupancy != '0);
        rsv2     = rsv1 && res_valid2 && (occupancy >= OW'(2));
        mis1     = rsv1 && is_mispredict(head_ent1, res_taken1, res_target1);
        mis2     = rsv2 && !mis1 && is_mispredict(head_ent2, res_taken2, res_target2);
        any_mis  = mis1 || mis2;
        pop_cnt  = {1'b0, rsv1} + {1'b0, rsv2 && !mis1};
        corr_pc1 = res_taken1 ? res_target1 : next_seq_pc(head_ent1.pc);
        corr_pc2 = res_taken2 ? res_target2 : next_seq_pc(head_ent2.pc);
    end

    // A mispredict empties the queue and also squashes this cycle's wrong-path enqueues.
    branch_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .clear     (any_mis),
        .wr_en1    (acc1 && !any_mis),
        .wr_en2    (acc2 && !any_mis),
        .wr_dat1   (enq_ent1),
        .wr_dat2   (enq_ent2),
        .pop_cnt   (pop_cnt),
        .rd_dat1   (head_ent1),
        .rd_dat2   (head_ent2),
        .occupancy (occupancy)
    );

    // Registered update bus, flush pulse, redirect PC and saturating mispredict counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            upd_branch1      <= 1'b0;
            upd_branch2      <= 1'b0;
            upd_taken1       <= 1'b0;
            upd_taken2       <= 1'b0;
            upd_pc1          <= '0;
            upd_pc2          <= '0;
            upd_target1      <= '0;
            upd_target2      <= '0;
            flush            <= 1'b0;
            redirect_pc      <= '0;
            mispredict_count <= '0;
        end else begin
            upd_branch1 <= rsv1;
            upd_branch2 <= rsv2 && !mis1;
            upd_taken1  <= res_taken1;
            upd_taken2  <= res_taken2;
            upd_pc1     <= head_ent1.pc;
            upd_pc2     <= head_ent2.pc;
            upd_target1 <= res_target1;
            upd_target2 <= res_target2;
            flush       <= any_mis;
            redirect_pc <= mis1 ? corr_pc1 : corr_pc2;
            if (any_mis && (mispredict_count != '1)) begin
                mispredict_count <= mispredict_count + CNT_W'(1);
            end
        end
    end

endmodule
